// File: rtl/generic_acc_pkg.sv
// Shared definitions for the generic accumulator: FSM state encoding and count width.
package generic_acc_pkg;

    localparam int CNT_W = 8;

    typedef logic [1:0] acc_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/generic_acc_addsat.sv
// Adder stage for the accumulator: add, carry-out detect and optional clamp.
// Clamping is built only when GENERIC_ACC_SATURATE_EN is defined; otherwise the sum wraps.
module generic_acc_addsat
    import generic_acc_pkg::*;
#(
    parameter int Dbitwidth = 22,
    parameter int Obitwidth = 32
) (
    input  logic [Obitwidth-1:0] acc_in,
    input  logic [Dbitwidth-1:0] data_in,
    input  logic                 sat_hold,
    output logic [Obitwidth-1:0] sum_out,
    output logic                 carry_out
);

    logic [Obitwidth:0] full_sum;

    always_comb begin
        full_sum  = {1'b0, acc_in} + {{(Obitwidth - Dbitwidth + 1){1'b0}}, data_in};
        carry_out = full_sum[Obitwidth];
`ifdef GENERIC_ACC_SATURATE_EN
        // once a frame has clamped it stays at all ones until acknowledged
        sum_out = (carry_out || sat_hold) ? {Obitwidth{1'b1}} : full_sum[Obitwidth-1:0];
`else
        sum_out = full_sum[Obitwidth-1:0];
`endif
    end

`ifndef GENERIC_ACC_SATURATE_EN
    logic unused_sat_hold;
    assign unused_sat_hold = sat_hold;
`endif

endmodule

// File: rtl/generic_accumulator_handshake.sv
// Frame accumulator: sums NSAMPLES valid/ready samples, then holds the result until out_ack.
// Optional clamping on overflow is selected with the GENERIC_ACC_SATURATE_EN macro.
//
// Handshake: a sample is taken on a posedge with in_valid && in_ready; in_ready is low only
// while a completed frame is held. out_valid stays high with stable outputs until out_ack.
module generic_accumulator_handshake
    import generic_acc_pkg::*;
#(
    parameter int Dbitwidth = 22,
    parameter int Obitwidth = 32,
    parameter int NSAMPLES  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [Dbitwidth-1:0] data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Obitwidth-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 overflow,
    output logic [CNT_W-1:0]     count_out,
    output logic [1:0]           state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSAMPLES);

    acc_state_t           state_q, state_d;
    logic [Obitwidth-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic [Obitwidth-1:0] add_base;
    logic [Obitwidth-1:0] add_sum;
    logic                 add_carry;
    logic                 sat_hold;

    assign in_ready = (state_q != ST_HOLD);
    assign accept   = in_valid && in_ready;

    // The first sample of a frame starts from zero, so its carry is always clear.
    assign add_base = (state_q == ST_ACCUM) ? acc_q : '0;
    assign sat_hold = (state_q == ST_ACCUM) && ovf_q;

    generic_acc_addsat #(
        .Dbitwidth(Dbitwidth),
        .Obitwidth(Obitwidth)
    ) u_addsat (
        .acc_in   (add_base),
        .data_in  (data_in),
        .sat_hold (sat_hold),
        .sum_out  (add_sum),
        .carry_out(add_carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                    if (LAST_CNT == CNT_W'(1)) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    if (cnt_q + CNT_W'(1) == LAST_CNT) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ack) begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_out   = acc_q;
    assign count_out = cnt_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_generic_accumulator_handshake.sv
// Bench for generic_accumulator_handshake: three instances (default, 22-bit output, single-sample frames).
module tb_generic_accumulator_handshake;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];

    // instance A: defaults (D=22, O=32, N=4)
    logic [21:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ack = 1'b0;
    logic        a_rdy;
    logic [31:0] a_acc;
    logic        a_ov;
    logic        a_ovf;
    logic [7:0]  a_cnt;
    logic [1:0]  a_st;

    // instance B: D=22, O=22, N=4
    logic [21:0] b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ack = 1'b0;
    logic        b_rdy;
    logic [21:0] b_acc;
    logic        b_ov;
    logic        b_ovf;
    logic [7:0]  b_cnt;
    logic [1:0]  b_st;

    // instance C: N=1
    logic [21:0] c_data = '0;
    logic        c_valid = 1'b0;
    logic        c_ack = 1'b0;
    logic        c_rdy;
    logic [31:0] c_acc;
    logic        c_ov;
    logic        c_ovf;
    logic [7:0]  c_cnt;
    logic [1:0]  c_st;

    generic_accumulator_handshake u_dut_a (
        .clock(clk), .reset(rst), .data_in(a_data), .in_valid(a_valid), .in_ready(a_rdy),
        .acc_out(a_acc), .out_valid(a_ov), .out_ack(a_ack), .overflow(a_ovf),
        .count_out(a_cnt), .state_dbg(a_st)
    );

    generic_accumulator_handshake #(.Dbitwidth(22), .Obitwidth(22), .NSAMPLES(4)) u_dut_b (
        .clock(clk), .reset(rst), .data_in(b_data), .in_valid(b_valid), .in_ready(b_rdy),
        .acc_out(b_acc), .out_valid(b_ov), .out_ack(b_ack), .overflow(b_ovf),
        .count_out(b_cnt), .state_dbg(b_st)
    );

    generic_accumulator_handshake #(.NSAMPLES(1)) u_dut_c (
        .clock(clk), .reset(rst), .data_in(c_data), .in_valid(c_valid), .in_ready(c_rdy),
        .acc_out(c_acc), .out_valid(c_ov), .out_ack(c_ack), .overflow(c_ovf),
        .count_out(c_cnt), .state_dbg(c_st)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Result of a whole frame from the arithmetic total of its samples: {overflow, acc}.
    function automatic logic [32:0] model_frame(input longint unsigned total, input int ob);
        longint unsigned lim;
        lim = 64'd1 << ob;
        if (total >= lim) begin
`ifdef GENERIC_ACC_SATURATE_EN
            return {1'b1, 32'(lim - 64'd1)};
`else
            return {1'b1, 32'(total % lim)};
`endif
        end
        return {1'b0, 32'(total)};
    endfunction

    // ---------------- driver tasks (enter and leave at a negedge) ----------------
    task automatic a_send(input logic [21:0] d);
        a_data = d; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [21:0] d);
        b_data = d; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic a_ack_frame();
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_acc !== 32'd0 || a_cnt !== 8'd0 || a_ov !== 1'b0 || a_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_a got acc=%0d cnt=%0d ov=%b ovf=%b required all 0", a_acc, a_cnt, a_ov, a_ovf); end
        checks++; if (a_rdy !== 1'b1 || a_st !== 2'd0) begin
            errors++; $display("FAIL reset_a_ready got rdy=%b st=%0d required rdy=1 st=0", a_rdy, a_st); end
        checks++; if (b_acc !== 22'd0 || b_cnt !== 8'd0 || b_ov !== 1'b0 || b_ovf !== 1'b0 || b_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_b got acc=%0d cnt=%0d ov=%b ovf=%b rdy=%b", b_acc, b_cnt, b_ov, b_ovf, b_rdy); end
        checks++; if (c_acc !== 32'd0 || c_cnt !== 8'd0 || c_ov !== 1'b0 || c_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_c got acc=%0d cnt=%0d ov=%b rdy=%b", c_acc, c_cnt, c_ov, c_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] s[4];
        s = '{22'd10, 22'd20, 22'd30, 22'd40};
        for (int i = 0; i < 3; i++) begin
            a_data = s[i]; a_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (a_ov !== 1'b0 || a_cnt !== 8'd3 || a_acc !== 32'd60) begin
            errors++; $display("FAIL b2b_partial got ov=%b cnt=%0d acc=%0d required 0/3/60", a_ov, a_cnt, a_acc); end
        a_send(s[3]);
        checks++; if (a_ov !== 1'b1 || a_acc !== 32'd100 || a_cnt !== 8'd4 || a_ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_result got ov=%b acc=%0d cnt=%0d ovf=%b required 1/100/4/0", a_ov, a_acc, a_cnt, a_ovf); end
        checks++; if (a_rdy !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_in_hold got %b required 0", a_rdy); end
        a_ack_frame();
        checks++; if (a_ov !== 1'b0 || a_acc !== 32'd0 || a_cnt !== 8'd0 || a_ovf !== 1'b0 || a_st !== 2'd0) begin
            errors++; $display("FAIL b2b_after_ack got ov=%b acc=%0d cnt=%0d ovf=%b st=%0d required zeros", a_ov, a_acc, a_cnt, a_ovf, a_st); end
    endtask

    task automatic test_hold_stall();
        for (int i = 1; i <= 4; i++) a_send(22'(i));
        a_data = 22'd99; a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_rdy !== 1'b0 || a_acc !== 32'd10 || a_cnt !== 8'd4 || a_ov !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc=%0d got rdy=%b acc=%0d cnt=%0d ov=%b required 0/10/4/1", i, a_rdy, a_acc, a_cnt, a_ov); end
            if (i == 4) a_ack = 1'b1;
            @(negedge clk);
        end
        a_ack = 1'b0;
        checks++; if (a_acc !== 32'd0 || a_cnt !== 8'd0 || a_st !== 2'd0 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL stall_ack_no_absorb got acc=%0d cnt=%0d st=%0d rdy=%b required 0/0/0/1", a_acc, a_cnt, a_st, a_rdy); end
        // still valid: first sample of the next frame is taken one cycle after leaving HOLD
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_acc !== 32'd99 || a_cnt !== 8'd1) begin
            errors++; $display("FAIL stall_next_frame got acc=%0d cnt=%0d required 99/1", a_acc, a_cnt); end
        for (int i = 0; i < 3; i++) a_send(22'd1);
        checks++; if (a_acc !== 32'd102 || a_ov !== 1'b1) begin
            errors++; $display("FAIL stall_frame2 got acc=%0d ov=%b required 102/1", a_acc, a_ov); end
        a_ack_frame();
    endtask

    task automatic test_overflow();
        logic [32:0] exp;
        b_send(22'h3FFFFF); b_send(22'h000002); b_send(22'd1); b_send(22'd1);
        exp = model_frame(64'h3FFFFF + 64'd4, 22);
        checks++; if (b_acc !== exp[21:0] || b_ovf !== exp[32] || b_ov !== 1'b1) begin
            errors++; $display("FAIL overflow_frame got acc=%h ovf=%b ov=%b required acc=%h ovf=%b", b_acc, b_ovf, b_ov, exp[21:0], exp[32]); end
        b_ack = 1'b1; @(negedge clk); b_ack = 1'b0;
        checks++; if (b_ovf !== 1'b0 || b_acc !== 22'd0) begin
            errors++; $display("FAIL overflow_clear got ovf=%b acc=%h required 0/0", b_ovf, b_acc); end
    endtask

    task automatic test_reset_mid_frame();
        a_send(22'd10); a_send(22'd20);
        checks++; if (a_acc !== 32'd30 || a_cnt !== 8'd2 || a_st !== 2'd1) begin
            errors++; $display("FAIL midreset_pre got acc=%0d cnt=%0d st=%0d required 30/2/1", a_acc, a_cnt, a_st); end
        rst = 1'b1; a_valid = 1'b1; a_data = 22'd50; a_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0; a_ack = 1'b0;
        checks++; if (a_acc !== 32'd0 || a_cnt !== 8'd0 || a_st !== 2'd0 || a_ov !== 1'b0 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL midreset_clear got acc=%0d cnt=%0d st=%0d ov=%b rdy=%b", a_acc, a_cnt, a_st, a_ov, a_rdy); end
        for (int i = 0; i < 4; i++) a_send(22'd5);
        checks++; if (a_acc !== 32'd20 || a_ov !== 1'b1 || a_cnt !== 8'd4) begin
            errors++; $display("FAIL midreset_frame got acc=%0d ov=%b cnt=%0d required 20/1/4", a_acc, a_ov, a_cnt); end
        a_ack_frame();
    endtask

    task automatic test_single_sample();
        c_ack = 1'b1; @(negedge clk); c_ack = 1'b0;
        checks++; if (c_st !== 2'd0 || c_ov !== 1'b0 || c_rdy !== 1'b1 || c_acc !== 32'd0) begin
            errors++; $display("FAIL single_idle_ack got st=%0d ov=%b rdy=%b acc=%0d", c_st, c_ov, c_rdy, c_acc); end
        c_data = 22'd7; c_valid = 1'b1; @(negedge clk); c_valid = 1'b0;
        checks++; if (c_ov !== 1'b1 || c_acc !== 32'd7 || c_cnt !== 8'd1 || c_ovf !== 1'b0 || c_rdy !== 1'b0) begin
            errors++; $display("FAIL single_result got ov=%b acc=%0d cnt=%0d ovf=%b rdy=%b required 1/7/1/0/0", c_ov, c_acc, c_cnt, c_ovf, c_rdy); end
        c_ack = 1'b1; @(negedge clk); c_ack = 1'b0;
        checks++; if (c_ov !== 1'b0 || c_acc !== 32'd0 || c_cnt !== 8'd0) begin
            errors++; $display("FAIL single_ack got ov=%b acc=%0d cnt=%0d required zeros", c_ov, c_acc, c_cnt); end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 24; f++) begin
            longint unsigned total;
            logic [21:0] s;
            logic [32:0] exp;
            bit big;
            int budget;
            total = 0;
            big = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    b_valid = 1'b0;
                    @(negedge clk);
                    checks++; if (b_cnt !== 8'(k) || b_ov !== 1'b0) begin
                        errors++; $display("FAIL rand_gap f=%0d got cnt=%0d ov=%b required cnt=%0d ov=0", f, b_cnt, b_ov, k); end
                end
                s = big ? 22'($urandom_range(22'h200000, 22'h3FFFFF)) : 22'($urandom_range(0, 4095));
                total += longint'(s);
                b_send(s);
                checks++; if (b_cnt !== 8'(k + 1)) begin
                    errors++; $display("FAIL rand_count f=%0d got %0d required %0d", f, b_cnt, k + 1); end
            end
            exp_q.push_back(model_frame(total, 22));
            budget = 4;
            while (b_ov !== 1'b1 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            exp = exp_q.pop_front();
            checks++; if (b_ov !== 1'b1) begin
                errors++; $display("FAIL rand_out_valid_timeout f=%0d got ov=%b required 1", f, b_ov);
            end else if (b_acc !== exp[21:0] || b_ovf !== exp[32]) begin
                errors++; $display("FAIL rand_frame f=%0d got acc=%h ovf=%b required acc=%h ovf=%b", f, b_acc, b_ovf, exp[21:0], exp[32]);
            end
            repeat ($urandom_range(0, 3)) begin
                b_valid = 1'($urandom_range(0, 1)); b_data = 22'($urandom);
                @(negedge clk);
                checks++; if (b_ov !== 1'b1 || b_rdy !== 1'b0 || b_acc !== exp[21:0] || b_cnt !== 8'd4) begin
                    errors++; $display("FAIL rand_hold f=%0d got ov=%b rdy=%b acc=%h cnt=%0d", f, b_ov, b_rdy, b_acc, b_cnt); end
            end
            b_ack = 1'b1; @(negedge clk); b_ack = 1'b0; b_valid = 1'b0;
            checks++; if (b_ov !== 1'b0 || b_acc !== 22'd0 || b_cnt !== 8'd0 || b_ovf !== 1'b0) begin
                errors++; $display("FAIL rand_ack f=%0d got ov=%b acc=%h cnt=%0d ovf=%b", f, b_ov, b_acc, b_cnt, b_ovf); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_hold_stall();
        test_overflow();
        test_reset_mid_frame();
        test_single_sample();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
